pid_err_src: RTL and testbench
==============================

# pid_err_src

Error-source front end for the heading PID loop. It captures each heading sample, forms the wrapped heading error against the desired heading, saturates it to 10 bits, and emits it with a one-cycle `err_vld` strobe for the downstream integrator and derivative terms. It also provides post-start blanking, a settled-at-heading indicator, and an optional sample-to-sample difference for the D path.

## Interface
Parameters:
- `BLANK_CNT`, default 2: valid samples suppressed after `moving` rises (0 = none).
- `SETTLE_THRESH`, default 32: `|err_sat|` must be strictly below this to count as settled.
- `SETTLE_CNT`, default 8: consecutive settled samples required to assert `at_hdng`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `moving` in 1: loop enabled; low clears pipeline and state.
- `hdng` in 12 signed: measured heading.
- `dsrd_hdng` in 12 signed: desired heading.
- `hdng_vld` in 1: `hdng` valid this cycle; may be high every cycle.
- `err_sat` out 10 signed: saturated heading error.
- `err_vld` out 1: one-cycle strobe per accepted sample.
- `at_hdng` out 1: heading settled.
- `D_diff` out 11 signed: `err_sat` minus previous `err_sat` (see Configuration).

## Operation
- **Stage 1.** On `hdng_vld & moving`, register `err_raw = hdng - dsrd_hdng` computed modulo 4096 as a 12-bit two's-complement value. Range is [-2048, 2047], and heading wrap is handled intrinsically. Set `s1_vld`.
- **Stage 2.** On `s1_vld`, register `err_sat = sat(err_raw)`, clamped to [-512, 511]. Then:
  - If `blank_cnt != 0`: decrement `blank_cnt`; `err_vld` stays 0, but `err_sat` still updates.
  - Else: pulse `err_vld` for one cycle.
  - `err_sat` holds its value between samples.
- **Blanking.** `blank_cnt` loads `BLANK_CNT` whenever `moving == 0`.
- **Settle detector.**
  - On each `err_vld`: if `|err_sat| < SETTLE_THRESH`, increment `settle_cnt`, saturating at `SETTLE_CNT`. Otherwise clear `settle_cnt` and drop `at_hdng` in the same cycle.
  - `at_hdng` asserts on the cycle after `settle_cnt` reaches `SETTLE_CNT`.
  - `at_hdng` is sticky until an out-of-threshold sample or `moving == 0`.
  - Blanked samples do not count toward settling.
- **moving low (level).** Clears `s1_vld`, `err_vld`, `settle_cnt`, `at_hdng`, and the diff history. Any in-flight sample is dropped. `err_sat` is cleared to 0.
- **moving toggling.** Re-rising `moving` restarts blanking.
- **Arithmetic.** `|x|` is computed at 11 bits so that -512 is handled. `D_diff` is 11-bit signed, range [-1023, 1023], with no saturation needed.

## Timing
- **Reset values.** `err_sat = 0`, `err_vld = 0`, `at_hdng = 0`, `D_diff = 0`; all counters cleared; `blank_cnt = BLANK_CNT`.
- **Latency.** `hdng_vld` sampled at edge N produces `err_sat`/`err_vld` visible after edge N+1, i.e. 2 cycles.
- **Throughput.** One sample per cycle; no backpressure.
- **Unconditional update.** `err_sat`, `err_vld`, and `D_diff` update together on the same edge.
- **Reset mid-operation.** Asynchronous reset returns all state to reset values immediately.

## Configuration
- **`PID_ERR_DIFF_EN` defined:**
  - Keep a 10-bit `prev_err` register, updated on each `err_vld`.
  - `D_diff = err_sat - prev_err`, registered alongside `err_sat`.
  - On the first unblanked sample after `moving` rises, `prev_err` is taken as the current value, so `D_diff = 0`.
- **`PID_ERR_DIFF_EN` undefined:** `D_diff` is tied to 0 and no history register exists. The port list is unchanged.

## Structure
- **Package `pid_pkg`:**
  - `HDNG_W = 12`, `ERR_W = 10`, `DIFF_W = 11`.
  - `ERR_MAX = 511`, `ERR_MIN = -512`.
  - Typedefs `hdng_t`, `err_t`, `diff_t`.
  - Function `sat_err(hdng_t) -> err_t`.
- **Sub-module `hdng_settle`:** the settle counter and `at_hdng` flag. Inputs are `err_vld`, `err_sat`, and `moving`; thresholds are passed as parameters.

## Test plan
- **Reset.** Hold `rst_n = 0` with random inputs → all outputs 0. Release with `moving = 0` and pulse `hdng_vld` → `err_vld` never asserts.
- **Blanking and latency.** `BLANK_CNT = 2`, `moving = 1`, `dsrd_hdng = 0`, `hdng = 100`, `hdng_vld` every cycle → first `err_vld` appears 2 cycles after the 3rd `hdng_vld`, with `err_sat = 100`. Strobes continue every cycle after that.
- **Saturation and wrap.**
  - `hdng = 1000`, `dsrd = 0` → `err_sat = 511`.
  - `hdng = -1000`, `dsrd = 0` → `err_sat = -512`.
  - `hdng = 2047`, `dsrd = -2048` → `err_sat = -1`.
- **Settle.** 8 consecutive samples with error 5 → `at_hdng` rises the cycle after the 8th `err_vld`. Then one sample with error -40 → `at_hdng` falls with that `err_vld`.
- **moving drop mid-pipeline.** `hdng_vld` at cycle N, `moving = 0` at cycle N+1 → no `err_vld` at N+2; `at_hdng = 0`, `err_sat = 0`.
- **`D_diff` (with `PID_ERR_DIFF_EN`).** Unblanked errors 100 then 130 then 90 → `D_diff` = 0, 30, -40. Without the macro, `D_diff` stays 0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared widths, limits and types for the heading PID error path.
package pid_pkg;

  localparam int unsigned HDNG_W = 12;
  localparam int unsigned ERR_W  = 10;
  localparam int unsigned DIFF_W = 11;

  localparam int ERR_MAX = 511;
  localparam int ERR_MIN = -512;

  typedef logic signed [HDNG_W-1:0] hdng_t;
  typedef logic signed [ERR_W-1:0]  err_t;
  typedef logic signed [DIFF_W-1:0] diff_t;

  // Clamp a wrapped 12-bit heading error into the 10-bit error range.
  function automatic err_t sat_err(hdng_t x);
    if (x > hdng_t'(ERR_MAX)) begin
      return err_t'(ERR_MAX);
    end else if (x < hdng_t'(ERR_MIN)) begin
      return err_t'(ERR_MIN);
    end else begin
      return x[ERR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/hdng_settle.sv
// Settle detector: counts consecutive in-threshold error strobes and raises a sticky at_hdng.
module hdng_settle
  import pid_pkg::*;
#(
  parameter int unsigned SETTLE_THRESH = 32,
  parameter int unsigned SETTLE_CNT    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic moving,
  input  logic err_vld,
  input  err_t err_sat,
  output logic at_hdng
);

  localparam int unsigned CntW = (SETTLE_CNT > 0) ? $clog2(SETTLE_CNT + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_q, at_d;
  diff_t           err_ext;
  diff_t           err_mag;
  logic            in_thresh;

  // Magnitude at 11 bits so that -512 maps to +512 without overflow.
  assign err_ext   = diff_t'(err_sat);
  assign err_mag   = (err_ext < 0) ? -err_ext : err_ext;
  assign in_thresh = int'(err_mag) < int'(SETTLE_THRESH);

  always_comb begin
    cnt_d = cnt_q;
    at_d  = at_q;
    if (!moving) begin
      cnt_d = '0;
      at_d  = 1'b0;
    end else if (err_vld) begin
      if (in_thresh) begin
        if (cnt_q != CntW'(SETTLE_CNT)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CntW'(SETTLE_CNT)) begin
          at_d = 1'b1;
        end
      end else begin
        cnt_d = '0;
        at_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      at_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      at_q  <= at_d;
    end
  end

  // An out-of-threshold strobe drops the flag in the same cycle it is presented.
  assign at_hdng = at_q & ~(err_vld & ~in_thresh);

endmodule

// File: rtl/pid_err_src.sv
// Heading error front end: wrap, saturate, blank after start, settle flag, optional D difference.
// Optional feature macro: PID_ERR_DIFF_EN enables the sample-to-sample D_diff output.
module pid_err_src
  import pid_pkg::*;
#(
  parameter int unsigned BLANK_CNT     = 2,
  parameter int unsigned SETTLE_THRESH = 32,
  parameter int unsigned SETTLE_CNT    = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  moving,
  input  hdng_t hdng,
  input  hdng_t dsrd_hdng,
  input  logic  hdng_vld,
  output err_t  err_sat,
  output logic  err_vld,
  output logic  at_hdng,
  output diff_t D_diff
);

  localparam int unsigned BlankW = (BLANK_CNT > 0) ? $clog2(BLANK_CNT + 1) : 1;

  logic              s1_vld_q, s1_vld_d;
  hdng_t             err_raw_q, err_raw_d;
  err_t              err_sat_q, err_sat_d;
  logic              err_vld_q, err_vld_d;
  logic [BlankW-1:0] blank_q, blank_d;
  err_t              err_new;
  logic              take_unblanked;

  assign err_new        = sat_err(err_raw_q);
  assign take_unblanked = moving & s1_vld_q & (blank_q == '0);

  always_comb begin
    s1_vld_d  = moving & hdng_vld;
    err_raw_d = err_raw_q;
    if (moving && hdng_vld) begin
      // 12-bit subtraction wraps modulo 4096, which handles heading wrap.
      err_raw_d = hdng - dsrd_hdng;
    end
  end

  always_comb begin
    err_sat_d = err_sat_q;
    err_vld_d = 1'b0;
    blank_d   = blank_q;
    if (!moving) begin
      err_sat_d = '0;
      blank_d   = BlankW'(BLANK_CNT);
    end else if (s1_vld_q) begin
      err_sat_d = err_new;
      if (blank_q != '0) begin
        blank_d = blank_q - 1'b1;
      end else begin
        err_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      err_raw_q <= '0;
      err_sat_q <= '0;
      err_vld_q <= 1'b0;
      blank_q   <= BlankW'(BLANK_CNT);
    end else begin
      s1_vld_q  <= s1_vld_d;
      err_raw_q <= err_raw_d;
      err_sat_q <= err_sat_d;
      err_vld_q <= err_vld_d;
      blank_q   <= blank_d;
    end
  end

  assign err_sat = err_sat_q;
  assign err_vld = err_vld_q;

`ifdef PID_ERR_DIFF_EN
  err_t  prev_q, prev_d;
  logic  first_q, first_d;
  diff_t diff_q, diff_d;

  always_comb begin
    prev_d  = prev_q;
    first_d = first_q;
    diff_d  = diff_q;
    if (!moving) begin
      prev_d  = '0;
      first_d = 1'b1;
      diff_d  = '0;
    end else if (take_unblanked) begin
      // First unblanked sample after start has no history, so it differences to zero.
      diff_d  = first_q ? '0 : (diff_t'(err_new) - diff_t'(prev_q));
      prev_d  = err_new;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      first_q <= 1'b1;
      diff_q  <= '0;
    end else begin
      prev_q  <= prev_d;
      first_q <= first_d;
      diff_q  <= diff_d;
    end
  end

  assign D_diff = diff_q;
`else
  logic unused_take;
  assign unused_take = take_unblanked;
  assign D_diff      = '0;
`endif

  hdng_settle #(
    .SETTLE_THRESH (SETTLE_THRESH),
    .SETTLE_CNT    (SETTLE_CNT)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .moving  (moving),
    .err_vld (err_vld_q),
    .err_sat (err_sat_q),
    .at_hdng (at_hdng)
  );

endmodule

// File: tb/tb_pid_err_src.sv
// Self-checking bench for pid_err_src: integer reference model plus directed literal checks.
module tb_pid_err_src;
  import pid_pkg::*;

  localparam int BLANK = 2;
  localparam int TH    = 32;
  localparam int SC    = 8;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  moving = 1'b0;
  logic  hdng_vld = 1'b0;
  hdng_t hdng = '0;
  hdng_t dsrd_hdng = '0;
  err_t  err_sat;
  logic  err_vld;
  logic  at_hdng;
  diff_t D_diff;

  always #5 clk = ~clk;

  pid_err_src #(
    .BLANK_CNT     (BLANK),
    .SETTLE_THRESH (TH),
    .SETTLE_CNT    (SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .moving    (moving),
    .hdng      (hdng),
    .dsrd_hdng (dsrd_hdng),
    .hdng_vld  (hdng_vld),
    .err_sat   (err_sat),
    .err_vld   (err_vld),
    .at_hdng   (at_hdng),
    .D_diff    (D_diff)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state, plain integers.
  int m_pend, m_pend_err, m_err, m_vld, m_blank, m_settle, m_at, m_prev, m_first, m_diff;

  function automatic int wrap12(int x);
    int y;
    y = x & 4095;
    return (y >= 2048) ? y - 4096 : y;
  endfunction

  function automatic int sat10(int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pend = 0; m_pend_err = 0; m_err = 0; m_vld = 0; m_blank = BLANK;
    m_settle = 0; m_at = 0; m_prev = 0; m_first = 1; m_diff = 0;
  endtask

  task automatic model_edge();
    if (!moving) begin
      model_clear();
    end else begin
      if (m_vld != 0) begin
        if (iabs(m_err) < TH) begin
          if (m_settle < SC) m_settle++;
          if (m_settle == SC) m_at = 1;
        end else begin
          m_settle = 0;
          m_at = 0;
        end
      end
      if (m_pend != 0) begin
        m_err = sat10(m_pend_err);
        if (m_blank > 0) begin
          m_blank--;
          m_vld = 0;
        end else begin
          m_vld = 1;
          m_diff = (m_first != 0) ? 0 : m_err - m_prev;
          m_prev = m_err;
          m_first = 0;
        end
      end else begin
        m_vld = 0;
      end
      m_pend = int'(hdng_vld);
      m_pend_err = wrap12(int'(hdng) - int'(dsrd_hdng));
    end
  endtask

  task automatic compare();
    int exp_at;
    exp_at = (m_at != 0 && !(m_vld != 0 && iabs(m_err) >= TH)) ? 1 : 0;
    chk("err_sat", int'(err_sat), m_err);
    chk("err_vld", int'(err_vld), m_vld);
    chk("at_hdng", int'(at_hdng), exp_at);
`ifdef PID_ERR_DIFF_EN
    if (m_vld != 0) chk("D_diff", int'(D_diff), m_diff);
`else
    chk("D_diff_zero", int'(D_diff), 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) model_clear();
    else model_edge();
    compare();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    compare();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [31:0] tmp;
    model_clear();

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      moving = 1'($urandom); hdng_vld = 1'($urandom);
      hdng = hdng_t'($urandom); dsrd_hdng = hdng_t'($urandom);
      step();
    end
    chk("reset_err_sat", int'(err_sat), 0);
    rst_n = 1'b1;
    moving = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hdng_vld = 1'(i);
      step();
    end

    // Blanking and latency.
    moving = 1'b1; dsrd_hdng = '0; hdng = 12'sd100; hdng_vld = 1'b1;
    step();
    step(); chk("blank_1", int'(err_vld), 0); chk("blank_1_sat", int'(err_sat), 100);
    step(); chk("blank_2", int'(err_vld), 0);
    step(); chk("first_vld", int'(err_vld), 1); chk("first_sat", int'(err_sat), 100);
    step(); chk("strobe_cont", int'(err_vld), 1);

    // Saturation and wrap.
    hdng = 12'sd1000; step(); step(); chk("sat_pos", int'(err_sat), 511);
    hdng = -12'sd1000; step(); step(); chk("sat_neg", int'(err_sat), -512);
    dsrd_hdng = -12'sd2048; hdng = 12'sd2047; step(); step(); chk("wrap", int'(err_sat), -1);

    // Settle.
    moving = 1'b0; step();
    moving = 1'b1; dsrd_hdng = '0; hdng = 12'sd5; hdng_vld = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 8; i++) begin
      step();
      if (err_vld) cnt++;
    end
    chk("settle_strobes", cnt, 8);
    chk("settle_not_yet", int'(at_hdng), 0);
    hdng = -12'sd40;
    step(); chk("settle_rise", int'(at_hdng), 1);
    hdng = 12'sd5;
    step(); chk("settle_fall", int'(at_hdng), 0); chk("settle_fall_sat", int'(err_sat), -40);

    // moving drop mid-pipeline.
    hdng = 12'sd7; hdng_vld = 1'b1; step();
    moving = 1'b0; hdng_vld = 1'b0; step();
    chk("drop_vld", int'(err_vld), 0);
    chk("drop_at", int'(at_hdng), 0);
    chk("drop_sat", int'(err_sat), 0);

    // D difference.
    moving = 1'b1; dsrd_hdng = '0; hdng = 12'sd100; hdng_vld = 1'b1;
    step(); step(); step();
    hdng = 12'sd130; step();
`ifdef PID_ERR_DIFF_EN
    chk("diff_first", int'(D_diff), 0);
`else
    chk("diff_off_a", int'(D_diff), 0);
`endif
    hdng = 12'sd90; step();
`ifdef PID_ERR_DIFF_EN
    chk("diff_up", int'(D_diff), 30);
`else
    chk("diff_off_b", int'(D_diff), 0);
`endif
    hdng_vld = 1'b0; step();
`ifdef PID_ERR_DIFF_EN
    chk("diff_down", int'(D_diff), -40);
`else
    chk("diff_off_c", int'(D_diff), 0);
`endif

    // Randomized phase against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) moving = ~moving;
      hdng_vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) dsrd_hdng = hdng_t'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        tmp = 32'(int'(dsrd_hdng) + int'($urandom_range(0, 80)) - 40);
      end else begin
        tmp = $urandom;
      end
      hdng = tmp[11:0];
      if ($urandom_range(0, 499) == 0) async_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
